elevator_request_scheduler: RTL and testbench
=============================================

// Module: elevator_request_scheduler
// PURPOSE
//  Request scheduler in front of the Elevator datapath. Latches floor calls into a pending mask.
//  Picks the next target with LOOK ordering: serve the current direction, then reverse.
//  Drives Elevator's floor_no/ip pair (sched_floor/sched_ip), one target at a time.
//  Uses curr_floor/door feedback to detect arrival, then dwells before choosing again.
// PARAMETERS
//  NUM_FLOORS    8  number of floors served; floors 0..NUM_FLOORS-1
//  FLOOR_W       3  floor index width, $clog2(NUM_FLOORS)
//  DWELL_CYCLES  4  cycles held in DWELL after arrival, >=1
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  req_floor    in   FLOOR_W     floor being called
//  req_valid    in   1           1-cycle call strobe, sampled on clk
//  curr_floor   in   FLOOR_W     elevator's current floor (Elevator curr_floor)
//  door         in   1           elevator door open (Elevator door)
//  sched_floor  out  FLOOR_W     target floor to Elevator floor_no, registered
//  sched_ip     out  1           1-cycle dispatch strobe to Elevator ip
//  pending      out  NUM_FLOORS  outstanding call mask
//  dir_up       out  1           1 = sweeping up, 0 = sweeping down
//  busy         out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset values: pending=0, sched_floor=0, sched_ip=0, dir_up=1, busy=0, state=IDLE, dwell_cnt=0.
//  Reset mid-operation: everything returns to reset values on the next edge; req_valid in that cycle is dropped.
//  Call capture: req_valid sets pending[req_floor] on the next edge.
//   - req_floor >= NUM_FLOORS: ignored.
//   - Duplicate calls: idempotent.
//  FSM states: IDLE, SELECT, DISPATCH, WAIT_ARRIVE, DWELL.
//   - IDLE -> SELECT when pending != 0.
//   - SELECT (LOOK): if pending[curr_floor], target = curr_floor.
//     Else take the nearest pending floor strictly in the dir_up direction.
//     If none, toggle dir_up and take the nearest in the opposite direction.
//     If still none (mask emptied), go to IDLE.
//     Register the target into sched_floor, then go to DISPATCH.
//   - DISPATCH: sched_ip=1 for exactly this one cycle; next state is WAIT_ARRIVE.
//   - WAIT_ARRIVE: arrival is curr_floor==sched_floor && door==1.
//     On arrival: clear pending[sched_floor], load dwell_cnt=DWELL_CYCLES-1, go to DWELL.
//     Retarget: if a newly set pending floor lies strictly between curr_floor and sched_floor
//     in the current direction, go to SELECT (re-dispatch to the nearer floor).
//     Retarget has lower priority than arrival.
//   - DWELL: decrement dwell_cnt; at 0 go to SELECT.
//  Latency: call accepted in IDLE -> sched_ip high 3 edges after the edge sampling req_valid
//   (pending set, SELECT, DISPATCH).
//  Simultaneous call and clear on the same floor: the clear wins; the call counts as served.
//  Calls arriving in any state are merged into pending; they never stall the FSM.
//  Ordering: sched_floor changes only on entry to DISPATCH; sched_ip never asserts on consecutive cycles.
//  Boundaries: floor 0 and floor NUM_FLOORS-1 are sweep ends.
//   - No wrap-around; direction toggles only in SELECT.
// STRUCTURE
//  elevator_pkg (shared): sched_state_e enum, NUM_FLOORS default, floor_t typedef.
//  Sub-module look_selector (combinational):
//   - inputs: pending, curr_floor, dir_up
//   - outputs: found, target, new_dir_up
//   - uses priority scans above/below curr_floor.
//  Top level holds the pending mask, FSM, dwell counter and output registers.
// TESTING
//  1 Reset: rst high 2 cycles mid-DWELL -> all outputs at reset values on the next edge; pending=0.
//  2 Single call: call floor 4 at curr_floor 0 -> sched_ip pulse with sched_floor=4, 3 edges later.
//    Model arrival (curr_floor=4, door=1) -> pending[4]=0, DWELL_CYCLES cycles, then IDLE.
//  3 LOOK order: calls 4, 6, 5 while at 0 going up -> dispatch sequence 4, 5, 6.
//    Then call 0 -> dir_up=0 and dispatch 0.
//  4 Retarget: en route from 0 to 6, call 3 while curr_floor=2 -> sched_floor=3 re-dispatched;
//    floor 6 stays pending and is served next.
//  5 Edge cases:
//    - Call floor 9 with NUM_FLOORS=8 -> ignored.
//    - Call = curr_floor while IDLE -> dispatch to the same floor.
//    - Call on the arriving floor in the arrival cycle -> bit cleared, no re-dispatch.
//  6 Saturation: all 8 floors called at once from floor 3 going up -> dispatch order 3,4,5,6,7,2,1,0.
//    sched_ip never high on 2 consecutive cycles.

Source files
------------

// File: rtl/elevator_request_scheduler_pkg.sv
// Shared types and default sizing for the elevator request scheduler and its LOOK selector.
package elevator_request_scheduler_pkg;

    localparam int NUM_FLOORS_DEF   = 8;
    localparam int FLOOR_W_DEF      = $clog2(NUM_FLOORS_DEF);
    localparam int DWELL_CYCLES_DEF = 4;

    typedef logic [FLOOR_W_DEF-1:0] floor_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_DISPATCH,
        S_WAIT_ARRIVE,
        S_DWELL
    } sched_state_e;

endpackage

// File: rtl/elevator_request_scheduler_look_selector.sv
// Combinational LOOK target picker: current floor first, then nearest in the sweep direction,
// then nearest in the opposite direction (with the direction flipped).
module look_selector
    import elevator_request_scheduler_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    curr_floor_i,
    input  logic                  dir_up_i,
    output logic                  found_o,
    output logic [FLOOR_W-1:0]    target_o,
    output logic                  new_dir_up_o
);

    logic               hereHit;
    logic               aboveHit;
    logic               belowHit;
    logic [FLOOR_W-1:0] aboveIdx;
    logic [FLOOR_W-1:0] belowIdx;

    // The downward scan leaves the lowest pending floor above; the upward scan leaves the highest below.
    always_comb begin
        hereHit  = 1'b0;
        aboveHit = 1'b0;
        belowHit = 1'b0;
        aboveIdx = '0;
        belowIdx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_i[i] && (i > int'(curr_floor_i))) begin
                aboveHit = 1'b1;
                aboveIdx = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_i[i] && (i < int'(curr_floor_i))) begin
                belowHit = 1'b1;
                belowIdx = FLOOR_W'(i);
            end
            if (pending_i[i] && (i == int'(curr_floor_i))) begin
                hereHit = 1'b1;
            end
        end
    end

    // An empty mask keeps the old direction; it only flips when a reverse target exists.
    always_comb begin
        found_o      = 1'b1;
        target_o     = curr_floor_i;
        new_dir_up_o = dir_up_i;
        if (!hereHit) begin
            if (dir_up_i && aboveHit) begin
                target_o = aboveIdx;
            end else if (!dir_up_i && belowHit) begin
                target_o = belowIdx;
            end else if (dir_up_i && belowHit) begin
                target_o     = belowIdx;
                new_dir_up_o = 1'b0;
            end else if (!dir_up_i && aboveHit) begin
                target_o     = aboveIdx;
                new_dir_up_o = 1'b1;
            end else begin
                found_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: collects floor calls, dispatches one LOOK-ordered target at a time
// to the elevator datapath and dwells after each arrival before choosing again.
module elevator_request_scheduler
    import elevator_request_scheduler_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int FLOOR_W      = $clog2(NUM_FLOORS),
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [FLOOR_W-1:0]    req_floor_i,
    input  logic                  req_valid_i,
    input  logic [FLOOR_W-1:0]    curr_floor_i,
    input  logic                  door_i,
    output logic [FLOOR_W-1:0]    sched_floor_o,
    output logic                  sched_ip_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  dir_up_o,
    output logic                  busy_o
);

    localparam int              DW_W       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);

    sched_state_e          state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    schedFloor_q, schedFloor_d;
    logic                  schedIp_q, schedIp_d;
    logic                  dirUp_q, dirUp_d;
    logic                  busy_q, busy_d;
    logic [DW_W-1:0]       dwellCnt_q, dwellCnt_d;

    logic [NUM_FLOORS-1:0] setMask;
    logic [NUM_FLOORS-1:0] clearMask;
    logic                  arrived;
    logic                  betweenHit;
    logic                  selFound;
    logic [FLOOR_W-1:0]    selTarget;
    logic                  selDirUp;

    look_selector #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_look_selector (
        .pending_i    (pending_q),
        .curr_floor_i (curr_floor_i),
        .dir_up_i     (dirUp_q),
        .found_o      (selFound),
        .target_o     (selTarget),
        .new_dir_up_o (selDirUp)
    );

    // Out-of-range calls match no mask bit; a clear on the arrival floor beats a same-cycle call.
    always_comb begin
        setMask    = '0;
        clearMask  = '0;
        betweenHit = 1'b0;
        arrived    = (state_q == S_WAIT_ARRIVE) && (curr_floor_i == schedFloor_q) && door_i;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req_valid_i && (int'(req_floor_i) == i)) begin
                setMask[i] = 1'b1;
            end
            if (arrived && (int'(schedFloor_q) == i)) begin
                clearMask[i] = 1'b1;
            end
            if (pending_q[i]) begin
                if (dirUp_q && (i > int'(curr_floor_i)) && (i < int'(schedFloor_q))) begin
                    betweenHit = 1'b1;
                end
                if (!dirUp_q && (i < int'(curr_floor_i)) && (i > int'(schedFloor_q))) begin
                    betweenHit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pending_d    = (pending_q | setMask) & ~clearMask;
        state_d      = state_q;
        schedFloor_d = schedFloor_q;
        dirUp_d      = dirUp_q;
        dwellCnt_d   = dwellCnt_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (selFound) begin
                    schedFloor_d = selTarget;
                    dirUp_d      = selDirUp;
                    state_d      = S_DISPATCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DISPATCH: begin
                state_d = S_WAIT_ARRIVE;
            end
            S_WAIT_ARRIVE: begin
                if (arrived) begin
                    dwellCnt_d = DWELL_LOAD;
                    state_d    = S_DWELL;
                end else if (betweenHit) begin
                    state_d = S_SELECT;
                end
            end
            S_DWELL: begin
                if (dwellCnt_q == '0) begin
                    state_d = S_SELECT;
                end else begin
                    dwellCnt_d = dwellCnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        schedIp_d = (state_d == S_DISPATCH);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            schedFloor_q <= '0;
            schedIp_q    <= 1'b0;
            dirUp_q      <= 1'b1;
            busy_q       <= 1'b0;
            dwellCnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            schedFloor_q <= schedFloor_d;
            schedIp_q    <= schedIp_d;
            dirUp_q      <= dirUp_d;
            busy_q       <= busy_d;
            dwellCnt_q   <= dwellCnt_d;
        end
    end

    assign sched_floor_o = schedFloor_q;
    assign sched_ip_o    = schedIp_q;
    assign pending_o     = pending_q;
    assign dir_up_o      = dirUp_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for the elevator request scheduler; the bench plays the elevator by driving
// curr_floor/door after each dispatch pulse.
module tb_elevator_request_scheduler;

    localparam int NF = 8;
    localparam int FW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] reqFloor = '0;
    logic          reqValid = 1'b0;
    logic [FW-1:0] currFloor = '0;
    logic          door = 1'b0;
    logic [FW-1:0] schedFloor;
    logic          schedIp;
    logic [NF-1:0] pending;
    logic          dirUp;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;
    int ipViol = 0;
    logic prevIp = 1'b0;

    elevator_request_scheduler #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_floor_i   (reqFloor),
        .req_valid_i   (reqValid),
        .curr_floor_i  (currFloor),
        .door_i        (door),
        .sched_floor_o (schedFloor),
        .sched_ip_o    (schedIp),
        .pending_o     (pending),
        .dir_up_o      (dirUp),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Watches for dispatch pulses on two consecutive cycles.
    always @(negedge clk) begin
        if (schedIp === 1'b1 && prevIp === 1'b1) ipViol++;
        prevIp = schedIp;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic callFloor(input logic [FW-1:0] f);
        reqFloor = f;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
    endtask

    task automatic waitForIp(input int budget, output logic seen, output logic [FW-1:0] f);
        seen = 1'b0;
        f = '0;
        for (int c = 0; c < budget && !seen; c++) begin
            tick();
            if (schedIp === 1'b1) begin
                seen = 1'b1;
                f = schedFloor;
            end
        end
    endtask

    task automatic waitIdle(input int budget, output logic idle);
        idle = 1'b0;
        for (int c = 0; c < budget && !idle; c++) begin
            tick();
            if (busy === 1'b0) idle = 1'b1;
        end
    endtask

    // Called right after the dispatch edge: DISPATCH -> WAIT_ARRIVE, then the arrival edge.
    task automatic serveArrival(input logic [FW-1:0] f);
        currFloor = f;
        door = 1'b1;
        tick();
        tick();
        door = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_pending: got %0h, expected 0", pending); end
        vectors++; if (schedIp !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ip: got %0b, expected 0", schedIp); end
        vectors++; if (schedFloor !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_floor: got %0d, expected 0", schedFloor); end
        vectors++; if (dirUp !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_dir: got %0b, expected 1", dirUp); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single_call();
        currFloor = 4'd0;
        door = 1'b0;
        callFloor(4'd4);
        vectors++; if (pending !== 8'h10) begin miscompares++; $display("[TB] FAIL single_pending: got %0h, expected 10", pending); end
        vectors++; if (schedIp !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ip_early1: got %0b, expected 0", schedIp); end
        tick();
        vectors++; if (schedIp !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_select: got ip=%0b busy=%0b, expected ip=0 busy=1", schedIp, busy); end
        tick();
        vectors++; if (schedIp !== 1'b1 || schedFloor !== 4'd4) begin miscompares++; $display("[TB] FAIL single_dispatch: got ip=%0b floor=%0d, expected ip=1 floor=4", schedIp, schedFloor); end
        currFloor = 4'd4;
        door = 1'b1;
        tick();
        vectors++; if (schedIp !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ip_width: got %0b, expected 0", schedIp); end
        tick();
        door = 1'b0;
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("[TB] FAIL single_clear: got %0h, expected 0", pending); end
        repeat (4) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_dwell_len: got busy=%0b, expected 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_idle: got busy=%0b, expected 0", busy); end
    endtask

    task automatic test_look_order();
        logic seen;
        logic idle;
        logic [FW-1:0] f;
        currFloor = 4'd0;
        callFloor(4'd4);
        callFloor(4'd6);
        callFloor(4'd5);
        vectors++; if (schedIp !== 1'b1 || schedFloor !== 4'd4) begin miscompares++; $display("[TB] FAIL look_first: got ip=%0b floor=%0d, expected ip=1 floor=4", schedIp, schedFloor); end
        serveArrival(4'd4);
        waitForIp(20, seen, f);
        vectors++; if (!seen || f !== 4'd5) begin miscompares++; $display("[TB] FAIL look_second: got seen=%0b floor=%0d, expected seen=1 floor=5", seen, f); end
        serveArrival(4'd5);
        waitForIp(20, seen, f);
        vectors++; if (!seen || f !== 4'd6) begin miscompares++; $display("[TB] FAIL look_third: got seen=%0b floor=%0d, expected seen=1 floor=6", seen, f); end
        serveArrival(4'd6);
        waitIdle(20, idle);
        vectors++; if (!idle) begin miscompares++; $display("[TB] FAIL look_idle: got busy=%0b, expected 0", busy); end
        callFloor(4'd0);
        waitForIp(10, seen, f);
        vectors++; if (!seen || f !== 4'd0 || dirUp !== 1'b0) begin miscompares++; $display("[TB] FAIL look_reverse: got seen=%0b floor=%0d dir=%0b, expected seen=1 floor=0 dir=0", seen, f, dirUp); end
        serveArrival(4'd0);
        waitIdle(20, idle);
    endtask

    task automatic test_retarget();
        logic seen;
        logic idle;
        logic [FW-1:0] f;
        callFloor(4'd6);
        waitForIp(10, seen, f);
        vectors++; if (!seen || f !== 4'd6 || dirUp !== 1'b1) begin miscompares++; $display("[TB] FAIL retarget_first: got seen=%0b floor=%0d dir=%0b, expected seen=1 floor=6 dir=1", seen, f, dirUp); end
        tick();
        currFloor = 4'd2;
        callFloor(4'd3);
        waitForIp(10, seen, f);
        vectors++; if (!seen || f !== 4'd3) begin miscompares++; $display("[TB] FAIL retarget_floor: got seen=%0b floor=%0d, expected seen=1 floor=3", seen, f); end
        vectors++; if (pending !== 8'h48) begin miscompares++; $display("[TB] FAIL retarget_pending: got %0h, expected 48", pending); end
        serveArrival(4'd3);
        vectors++; if (pending !== 8'h40) begin miscompares++; $display("[TB] FAIL retarget_keep6: got %0h, expected 40", pending); end
        waitForIp(20, seen, f);
        vectors++; if (!seen || f !== 4'd6) begin miscompares++; $display("[TB] FAIL retarget_resume: got seen=%0b floor=%0d, expected seen=1 floor=6", seen, f); end
        serveArrival(4'd6);
        waitIdle(20, idle);
        vectors++; if (!idle || pending !== 8'h00) begin miscompares++; $display("[TB] FAIL retarget_done: got idle=%0b pending=%0h, expected idle=1 pending=0", idle, pending); end
    endtask

    task automatic test_edge_cases();
        logic seen;
        logic idle;
        logic [FW-1:0] f;
        callFloor(4'd9);
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("[TB] FAIL edge_range_pending: got %0h, expected 0", pending); end
        waitForIp(5, seen, f);
        vectors++; if (seen || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_range_idle: got seen=%0b busy=%0b, expected seen=0 busy=0", seen, busy); end
        callFloor(4'd6);
        waitForIp(10, seen, f);
        vectors++; if (!seen || f !== 4'd6) begin miscompares++; $display("[TB] FAIL edge_same_floor: got seen=%0b floor=%0d, expected seen=1 floor=6", seen, f); end
        serveArrival(4'd6);
        waitIdle(20, idle);
        callFloor(4'd2);
        waitForIp(10, seen, f);
        vectors++; if (!seen || f !== 4'd2 || dirUp !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_down: got seen=%0b floor=%0d dir=%0b, expected seen=1 floor=2 dir=0", seen, f, dirUp); end
        currFloor = 4'd2;
        door = 1'b1;
        tick();
        reqFloor = 4'd2;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        door = 1'b0;
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("[TB] FAIL edge_arrive_call: got %0h, expected 0", pending); end
        waitForIp(12, seen, f);
        vectors++; if (seen || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_no_redispatch: got seen=%0b busy=%0b, expected seen=0 busy=0", seen, busy); end
    endtask

    task automatic test_saturation();
        logic seen;
        logic idle;
        logic [FW-1:0] f;
        logic [FW-1:0] order [8] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd2, 4'd1, 4'd0};
        int nLog;
        logic [FW-1:0] firstFloor;
        callFloor(4'd3);
        waitForIp(10, seen, f);
        serveArrival(4'd3);
        waitIdle(20, idle);
        vectors++; if (!idle || dirUp !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_setup: got idle=%0b dir=%0b, expected idle=1 dir=1", idle, dirUp); end
        nLog = 0;
        firstFloor = '0;
        currFloor = 4'd3;
        door = 1'b1;
        for (int k = 0; k < 8; k++) begin
            reqFloor = order[k];
            reqValid = 1'b1;
            tick();
            if (schedIp === 1'b1) begin
                if (nLog == 0) firstFloor = schedFloor;
                nLog++;
            end
        end
        reqValid = 1'b0;
        door = 1'b0;
        vectors++; if (nLog != 1 || firstFloor !== order[0]) begin miscompares++; $display("[TB] FAIL sat_first: got count=%0d floor=%0d, expected count=1 floor=%0d", nLog, firstFloor, order[0]); end
        for (int k = 1; k < 8; k++) begin
            waitForIp(30, seen, f);
            vectors++; if (!seen || f !== order[k]) begin miscompares++; $display("[TB] FAIL sat_order%0d: got seen=%0b floor=%0d, expected seen=1 floor=%0d", k, seen, f, order[k]); end
            serveArrival(f);
        end
        waitIdle(20, idle);
        vectors++; if (!idle || pending !== 8'h00) begin miscompares++; $display("[TB] FAIL sat_done: got idle=%0b pending=%0h, expected idle=1 pending=0", idle, pending); end
        vectors++; if (ipViol != 0) begin miscompares++; $display("[TB] FAIL sat_ip_b2b: got %0d back-to-back pulses, expected 0", ipViol); end
    endtask

    task automatic test_reset_mid_dwell();
        logic seen;
        logic idle;
        logic [FW-1:0] f;
        callFloor(4'd5);
        waitForIp(10, seen, f);
        serveArrival(4'd5);
        waitIdle(20, idle);
        callFloor(4'd2);
        waitForIp(10, seen, f);
        serveArrival(4'd2);
        callFloor(4'd6);
        vectors++; if (busy !== 1'b1 || pending !== 8'h40 || dirUp !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pre: got busy=%0b pending=%0h dir=%0b, expected busy=1 pending=40 dir=0", busy, pending, dirUp); end
        rst = 1'b1;
        reqFloor = 4'd1;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        vectors++; if (pending !== 8'h00 || schedIp !== 1'b0 || schedFloor !== 4'd0) begin miscompares++; $display("[TB] FAIL rst_mid_regs: got pending=%0h ip=%0b floor=%0d, expected pending=0 ip=0 floor=0", pending, schedIp, schedFloor); end
        vectors++; if (dirUp !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_state: got dir=%0b busy=%0b, expected dir=1 busy=0", dirUp, busy); end
        tick();
        rst = 1'b0;
        tick();
        tick();
        vectors++; if (pending !== 8'h00 || busy !== 1'b0 || schedIp !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_after: got pending=%0h busy=%0b ip=%0b, expected 0 0 0", pending, busy, schedIp); end
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_look_order();
        test_retarget();
        test_edge_cases();
        test_saturation();
        test_reset_mid_dwell();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
